// File: rtl/mts_pkg.sv
// Shared definitions for the MTS SYSREF generator and its capture-side checkers.
// Holds the sequencer state encoding and the shortest usable SYSREF period.
package mts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_END  = 2'd3
    } mts_state_e;

    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/sysref_phase_ctr.sv
// Loadable wrap counter for the SYSREF phase: ph counts 0..period-1 and wraps.
// high_next gives the high/low phase for the value ph takes after this edge.
module sysref_phase_ctr #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic [PERIOD_W-1:0] ph,
    output logic                at_last,
    output logic                high_next
);

    logic [PERIOD_W-1:0] ph_next;

    assign at_last = (ph == period - PERIOD_W'(1));

    always_comb begin
        ph_next = ph;
        if (clear) begin
            ph_next = '0;
        end else if (run) begin
            ph_next = at_last ? '0 : ph + PERIOD_W'(1);
        end
    end

    // High for the first floor(P/2) cycles of each period.
    assign high_next = (ph_next < (period >> 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            ph <= '0;
        end else begin
            ph <= ph_next;
        end
    end

endmodule

// File: rtl/sysref_gen.sv
// SYSREF pulse-train generator: counted burst or continuous train, optionally
// aligned to an external tick. All outputs come straight from flops.
module sysref_gen
    import mts_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [CNT_W-1:0]    npulse,
    input  logic                sync_en,
    input  logic                sync_tick,
    output logic                sysref,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    pulses_sent
);

    mts_state_e          state, state_d;
    logic [PERIOD_W-1:0] period_l, period_d, period_clamped;
    logic [CNT_W-1:0]    npulse_l;
    logic                sync_en_l;
    logic                stop_pend, stop_pend_d;
    logic                accept, clear, run;
    logic [PERIOD_W-1:0] ph;
    logic                at_last, high_next;
    logic                sysref_d;
    logic [CNT_W-1:0]    cnt_base, cnt_d;
    logic                burst_full;

    assign accept         = (state == ST_IDLE) && start;
    assign period_clamped = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
    // The counter must see the new period on the same edge that accepts start.
    assign period_d       = accept ? period_clamped : period_l;
    assign clear          = accept || ((state == ST_ARM) && !stop && sync_tick);
    assign run            = (state == ST_RUN);
    assign burst_full     = (npulse_l != '0) && (pulses_sent == npulse_l);

    sysref_phase_ctr #(
        .PERIOD_W (PERIOD_W)
    ) u_phase (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .run       (run),
        .period    (period_d),
        .ph        (ph),
        .at_last   (at_last),
        .high_next (high_next)
    );

    always_comb begin
        state_d     = state;
        stop_pend_d = stop_pend;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    stop_pend_d = 1'b0;
                    state_d     = sync_en ? ST_ARM : ST_RUN;
                end
            end
            ST_ARM: begin
                if (stop) begin
                    state_d = ST_END;
                end else if (sync_tick) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                // Only leave at the end of a full period so no high phase is cut short.
                if (at_last && (burst_full || stop_pend || stop)) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sysref_d = (state_d == ST_RUN) && high_next;
    assign cnt_base = accept ? '0 : pulses_sent;
    assign cnt_d    = (sysref_d && !sysref && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            period_l    <= PERIOD_W'(MIN_PERIOD);
            npulse_l    <= '0;
            sync_en_l   <= 1'b0;
            stop_pend   <= 1'b0;
            sysref      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
        end else begin
            state       <= state_d;
            stop_pend   <= stop_pend_d;
            sysref      <= sysref_d;
            busy        <= (state_d == ST_ARM) || (state_d == ST_RUN);
            done        <= (state_d == ST_END);
            pulses_sent <= cnt_d;
            if (accept) begin
                period_l  <= period_clamped;
                npulse_l  <= npulse;
                sync_en_l <= sync_en;
            end
        end
    end

endmodule

// File: tb/tb_sysref_gen.sv
// Bench for sysref_gen: a cycle-time model of the pulse train checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sysref_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period = 16'd0;
    logic [7:0]  npulse = 8'd0;
    logic        sync_en = 1'b0;
    logic        sync_tick = 1'b0;
    logic        sysref, busy, done;
    logic [7:0]  pulses_sent;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    sysref_gen #(.PERIOD_W(16), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .npulse      (npulse),
        .sync_en     (sync_en),
        .sync_tick   (sync_tick),
        .sysref      (sysref),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 waiting for tick, 2 running, 3 ending.
    // While running, k is cycles since the first rising edge of the train.
    int m_mode = 0, m_k = 0, m_P = 2, m_N = 0, m_cnt = 0;
    bit m_stopf = 0;
    bit exp_sysref = 0, exp_busy = 0, exp_done = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_stopf = 0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_P = (period < 2) ? 2 : int'(period);
                    m_N = int'(npulse);
                    m_stopf = 0;
                    m_cnt = 0;
                    if (sync_en) m_mode = 1;
                    else begin m_mode = 2; m_k = 0; end
                end
                1: if (stop) m_mode = 3;
                   else if (sync_tick) begin m_mode = 2; m_k = 0; end
                2: begin
                    if (stop) m_stopf = 1;
                    if ((m_k % m_P == m_P - 1) &&
                        ((m_N != 0 && m_k / m_P + 1 == m_N) || m_stopf)) m_mode = 3;
                    else m_k++;
                end
                default: m_mode = 0;
            endcase
        end
        if (m_mode == 2) m_cnt = (m_k / m_P + 1 > 255) ? 255 : m_k / m_P + 1;
        exp_sysref = (m_mode == 2) && (m_k % m_P < m_P / 2);
        exp_busy   = (m_mode == 1) || (m_mode == 2);
        exp_done   = (m_mode == 3);
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_sysref", sysref, exp_sysref);
            chk("model_busy", busy, exp_busy);
            chk("model_done", done, exp_done);
            chk("model_pulses_sent", pulses_sent, m_cnt);
        end
    end

    task automatic go(input int p, input int n, input bit se, input bit st, input bit tk);
        period = p[15:0]; npulse = n[7:0]; sync_en = se;
        start = 1'b1; stop = st; sync_tick = tk;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; sync_tick = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int waited);
        waited = 0;
        while (!done && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic run_burst();
        go(10, 3, 0, 0, 0);
        for (int o = 1; o <= 31; o++) begin
            chk("burst_sysref", sysref,
                ((o >= 1 && o <= 5) || (o >= 11 && o <= 15) || (o >= 21 && o <= 25)) ? 1 : 0);
            if (o == 31) begin
                chk("burst_done", done, 1);
                chk("burst_busy", busy, 0);
                chk("burst_count", pulses_sent, 3);
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int w;
        @(posedge clk);
        cmp_on = 1'b1;
        @(negedge clk);
        chk("reset_sysref", sysref, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_count", pulses_sent, 0);
        reset = 1'b0;
        @(negedge clk);

        run_burst();

        go(7, 2, 0, 0, 0);
        for (int o = 1; o <= 7; o++) begin
            chk("p7_sysref", sysref, (o <= 3) ? 1 : 0);
            @(negedge clk);
        end
        wait_done(20, w);
        @(negedge clk);

        go(0, 2, 0, 0, 0);
        for (int o = 1; o <= 4; o++) begin
            chk("p0_sysref", sysref, o % 2);
            @(negedge clk);
        end
        chk("p0_done", done, 1);
        chk("p0_count", pulses_sent, 2);
        @(negedge clk);

        go(1, 1, 0, 0, 0);
        chk("p1_high", sysref, 1);
        @(negedge clk);
        chk("p1_low", sysref, 0);
        @(negedge clk);
        chk("p1_done", done, 1);
        @(negedge clk);

        // Aligned start; the tick coincident with start must not be used.
        go(6, 1, 1, 0, 1);
        chk("align_busy", busy, 1);
        for (int o = 1; o <= 12; o++) begin
            chk("align_wait", sysref, 0);
            @(negedge clk);
        end
        chk("align_wait", sysref, 0);
        sync_tick = 1'b1;
        @(negedge clk);
        sync_tick = 1'b0;
        chk("align_rise", sysref, 1);
        wait_done(20, w);
        @(negedge clk);

        // Continuous, stop during the high phase of pulse 5 (offsets 33..36).
        go(8, 0, 0, 0, 0);
        repeat (33) @(negedge clk);
        chk("cont_p5_high", sysref, 1);
        chk("cont_p5_count", pulses_sent, 5);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(30, w);
        chk("stop_latency", w, 6);
        chk("stop_count", pulses_sent, 5);
        @(negedge clk);

        // start+stop together in IDLE, then a start while busy.
        go(4, 2, 0, 1, 0);
        chk("startstop_busy", busy, 1);
        @(negedge clk);
        period = 16'd3; npulse = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, w);
        chk("startstop_count", pulses_sent, 2);
        @(negedge clk);

        // stop while waiting for the tick.
        go(5, 3, 1, 0, 0);
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("arm_stop_done", done, 1);
        chk("arm_stop_count", pulses_sent, 0);
        @(negedge clk);

        // Counter saturation in continuous mode at period 2.
        go(0, 0, 0, 0, 0);
        repeat (520) @(negedge clk);
        chk("sat_count", pulses_sent, 255);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(4, w);
        chk("sat_final", pulses_sent, 255);
        @(negedge clk);

        // Reset mid-pulse, then a fresh burst.
        go(10, 3, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_pre_sysref", sysref, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_sysref", sysref, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", pulses_sent, 0);
        run_burst();

        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            sync_tick = ($urandom_range(0, 9) == 0);
            sync_en   = $urandom_range(0, 1);
            period    = 16'($urandom_range(0, 12));
            npulse    = 8'($urandom_range(0, 4));
            reset     = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0; sync_tick = 1'b0; reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
